// File: rtl/viterbi_pkg.sv
// Shared encoder/decoder definitions: trellis size, generators, encoder FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package viterbi_pkg;

    localparam int K          = 3;
    localparam int NUM_STATES = 4;

    // Generator taps, bit order {d, sr[1], sr[0]}
    localparam logic [K-1:0] G0_DEF = 3'b111;
    localparam logic [K-1:0] G1_DEF = 3'b101;

    typedef logic [1:0] sym_t;

    typedef enum logic [1:0] {
        DATA  = 2'd0,
        TAIL1 = 2'd1,
        TAIL2 = 2'd2
    } enc_state_t;

endpackage

// File: rtl/conv_encoder_tx_if.sv
// Bit-in / symbol-out handshake bundle for the convolutional encoder.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both sides; master is the source/sink side, slave the encoder.
interface conv_encoder_tx_if import viterbi_pkg::*; #(
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_bit;
    logic             in_last;
    logic             in_ready;
    logic             out_valid;
    sym_t             sym;
    logic             sym_last;
    logic             out_ready;
    logic [CNT_W-1:0] sym_cnt;
    logic             busy;

    modport master (
        output in_valid, in_bit, in_last, out_ready,
        input  in_ready, out_valid, sym, sym_last, sym_cnt, busy
    );

    modport slave (
        input  in_valid, in_bit, in_last, out_ready,
        output in_ready, out_valid, sym, sym_last, sym_cnt, busy
    );
endinterface

// File: rtl/conv_branch_out.sv
// Code symbol for one trellis branch: {c0, c1} from input bit d and shift register sr.
// Latency: combinational.
// Backpressure: none; pure function, also used for expected-branch symbols in the decoder.
module conv_branch_out import viterbi_pkg::*; (
    input  logic         d_i,
    input  logic [K-2:0] sr_i,
    input  logic [K-1:0] g0_i,
    input  logic [K-1:0] g1_i,
    output sym_t         sym_o
);
    logic [K-1:0] taps;

    assign taps  = {d_i, sr_i};
    assign sym_o = {^(g0_i & taps), ^(g1_i & taps)};
endmodule

// File: rtl/conv_encoder_tx.sv
// Rate-1/2 K=3 convolutional encoder; appends two zero tail bits per frame so the trellis ends in 00.
// Latency: accepted bit -> registered symbol valid on the next cycle; 1 symbol/cycle sustained.
// Backpressure: single output register; stalls while out_valid && !out_ready, in_ready follows out_ready.
module conv_encoder_tx import viterbi_pkg::*; #(
    parameter logic [K-1:0] G0    = G0_DEF,
    parameter logic [K-1:0] G1    = G1_DEF,
    parameter int           CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    conv_encoder_tx_if.slave     bus
);
    enc_state_t       state_q, state_d;
    logic [K-2:0]     sr_q, sr_d;
    logic             out_valid_q, out_valid_d;
    sym_t             sym_q, sym_d;
    logic             sym_last_q, sym_last_d;
    logic [CNT_W-1:0] sym_cnt_q, sym_cnt_d;
    // Next loaded symbol starts a new frame, so the counter restarts at 1
    logic             first_q, first_d;

    logic             can_load;
    logic             src_vld;
    logic             tail_last;
    logic             d_bit;
    logic             load;
    sym_t             br_sym;

    // Output register is free when empty or being drained this cycle
    assign can_load = !out_valid_q || bus.out_ready;
    assign load     = can_load && src_vld;

    conv_branch_out u_branch (
        .d_i   (d_bit),
        .sr_i  (sr_q),
        .g0_i  (G0),
        .g1_i  (G1),
        .sym_o (br_sym)
    );

    // State register; reset abandons any frame in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= DATA;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and symbol source selection: input bit in DATA, forced zero in the tail
    always_comb begin
        state_d   = state_q;
        src_vld   = 1'b0;
        tail_last = 1'b0;
        d_bit     = 1'b0;
        case (state_q)
            DATA: begin
                src_vld = bus.in_valid;
                d_bit   = bus.in_bit;
                if (bus.in_valid && can_load && bus.in_last) begin
                    state_d = TAIL1;
                end
            end
            TAIL1: begin
                src_vld = 1'b1;
                if (can_load) begin
                    state_d = TAIL2;
                end
            end
            TAIL2: begin
                src_vld   = 1'b1;
                tail_last = 1'b1;
                if (can_load) begin
                    state_d = DATA;
                end
            end
            default: begin
                state_d = DATA;
            end
        endcase
    end

    // Datapath next values: load replaces the held symbol, otherwise hold or drain
    always_comb begin
        sr_d        = sr_q;
        sym_d       = sym_q;
        sym_last_d  = sym_last_q;
        sym_cnt_d   = sym_cnt_q;
        first_d     = first_q;
        out_valid_d = out_valid_q;
        if (load) begin
            sr_d        = {d_bit, sr_q[K-2:1]};
            sym_d       = br_sym;
            sym_last_d  = tail_last;
            sym_cnt_d   = first_q ? CNT_W'(1) : sym_cnt_q + CNT_W'(1);
            first_d     = tail_last;
            out_valid_d = 1'b1;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Datapath registers; the held symbol is dropped on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q        <= '0;
            sym_q       <= '0;
            sym_last_q  <= 1'b0;
            sym_cnt_q   <= '0;
            first_q     <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            sr_q        <= sr_d;
            sym_q       <= sym_d;
            sym_last_q  <= sym_last_d;
            sym_cnt_q   <= sym_cnt_d;
            first_q     <= first_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = (state_q == DATA) && can_load;
    assign bus.out_valid = out_valid_q;
    assign bus.sym       = sym_q;
    assign bus.sym_last  = sym_last_q;
    assign bus.sym_cnt   = sym_cnt_q;
    assign bus.busy      = (state_q != DATA) || out_valid_q;

endmodule

// File: tb/tb_conv_encoder_tx.sv
// Bench for conv_encoder_tx: directed frames, scoreboard queue, negedge monitor.
// A second instance with a 3-bit counter shares the stimulus to exercise counter wrap.
// Expected symbols are hand-computed per frame.
module tb_conv_encoder_tx;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    conv_encoder_tx_if #(.CNT_W(16)) bus ();
    conv_encoder_tx_if #(.CNT_W(3))  bus2 ();

    assign bus2.in_valid  = bus.in_valid;
    assign bus2.in_bit    = bus.in_bit;
    assign bus2.in_last   = bus.in_last;
    assign bus2.out_ready = bus.out_ready;

    conv_encoder_tx #(.CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    conv_encoder_tx #(.CNT_W(3)) dut_w (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    typedef struct {
        logic [1:0] sym;
        logic       last;
        int         cnt;
    } exp_t;

    exp_t exp_q[$];

    int   cmp_n = 0;
    int   err_n = 0;
    int   cyc   = 0;
    bit   bp_en = 1'b0;
    bit   gap_chk = 1'b0;
    bit   have_prev = 1'b0;
    int   last_cyc = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        cmp_n++;
        if (act !== exp) begin
            err_n++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // syms packs 2 bits per symbol, first symbol in the most significant position
    task automatic push_frame(input logic [31:0] syms, input int n, input bit term);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.sym  = syms[2*(n-1-i) +: 2];
            e.last = term && (i == n - 1);
            e.cnt  = i + 1;
            exp_q.push_back(e);
        end
    endtask

    task automatic send_bit(input logic b, input logic last, output int w);
        bit acc;
        acc = 1'b0;
        w   = 0;
        bus.in_valid = 1'b1;
        bus.in_bit   = b;
        bus.in_last  = last;
        while (!acc && w < 100) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            if (!acc) w++;
        end
        if (!acc) check("send_timeout", 32'd0, 32'd1);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // bits packed first bit in the most significant position; in_last on the final bit
    task automatic send_frame(input logic [15:0] bits, input int n, output int first_wait);
        int w;
        first_wait = 0;
        for (int i = 0; i < n; i++) begin
            send_bit(bits[n-1-i], i == n - 1, w);
            if (i == 0) first_wait = w;
        end
    endtask

    task automatic drain(input string nm);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        #1;
        check(nm, exp_q.size(), 0);
        check({nm, "_busy"}, {31'd0, bus.busy}, 0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Sink ready: always 1, or the 1,0,0,1 pattern when backpressure is enabled
    initial begin
        int idx;
        logic [3:0] pat;
        pat = 4'b1001;
        idx = 0;
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_en) begin
                bus.out_ready = pat[3 - (idx % 4)];
                idx++;
            end else begin
                bus.out_ready = 1'b1;
                idx = 0;
            end
        end
    end

    // Monitor: pop and compare on each transfer; check hold stability during stalls
    initial begin
        exp_t e;
        bit   stall_prev;
        logic [18:0] held;
        stall_prev = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev)
                    check("stall_hold", {13'd0, bus.sym, bus.sym_last, bus.sym_cnt}, {13'd0, held});
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_sym", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("sym",        {30'd0, bus.sym},     {30'd0, e.sym});
                        check("sym_last",   {31'd0, bus.sym_last}, {31'd0, e.last});
                        check("sym_cnt",    {16'd0, bus.sym_cnt}, e.cnt);
                        check("w_valid",    {31'd0, bus2.out_valid}, 32'd1);
                        check("w_sym",      {30'd0, bus2.sym},    {30'd0, e.sym});
                        check("w_sym_cnt",  {29'd0, bus2.sym_cnt}, e.cnt % 8);
                    end
                    if (gap_chk) begin
                        if (have_prev) check("no_gap", cyc - last_cyc, 1);
                        have_prev = 1'b1;
                        last_cyc  = cyc;
                    end
                end
                stall_prev = bus.out_valid && !bus.out_ready;
                held = {bus.sym, bus.sym_last, bus.sym_cnt};
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        bus.in_valid = 1'b0;
        bus.in_bit   = 1'b0;
        bus.in_last  = 1'b0;

        // Reset values, asynchronously visible
        #2;
        check("rst_out_valid", {31'd0, bus.out_valid}, 0);
        check("rst_sym_cnt",   {16'd0, bus.sym_cnt},   0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", {31'd0, bus.in_ready}, 1);
        check("rst_sym",      {30'd0, bus.sym},      0);
        check("rst_sym_last", {31'd0, bus.sym_last}, 0);
        check("rst_busy",     {31'd0, bus.busy},     0);
        @(posedge clk);
        #1;

        // Basic frame 1,0,1,1 -> 11,10,00,01,01,11
        push_frame(32'b11_10_00_01_01_11, 6, 1'b1);
        send_frame(16'b1011, 4, w);
        check("basic_wait", w, 0);
        drain("basic_drain");

        // Single-bit frame, next frame's bit held off until TAIL2 loads
        push_frame(32'b11_10_11, 3, 1'b1);
        push_frame(32'b00_00_00, 3, 1'b1);
        send_frame(16'b1, 1, w);
        send_frame(16'b0, 1, w);
        check("single_holdoff_cycles", w, 2);
        drain("single_drain");

        // Backpressure on the basic frame
        bp_en = 1'b1;
        push_frame(32'b11_10_00_01_01_11, 6, 1'b1);
        send_frame(16'b1011, 4, w);
        drain("bp_drain");
        bp_en = 1'b0;
        @(posedge clk);
        #1;

        // Back-to-back frames 0,1(last) then 1(last) with no output gap
        gap_chk   = 1'b1;
        have_prev = 1'b0;
        push_frame(32'b00_11_10_11, 4, 1'b1);
        push_frame(32'b11_10_11, 3, 1'b1);
        send_frame(16'b01, 2, w);
        send_frame(16'b1, 1, w);
        check("b2b_second_wait", w, 2);
        drain("b2b_drain");
        gap_chk = 1'b0;

        // Reset after two bits: only the first symbol is ever transferred
        push_frame(32'b11, 1, 1'b0);
        send_bit(1'b1, 1'b0, w);
        send_bit(1'b0, 1'b0, w);
        #1 rst = 1'b1;
        #1;
        check("midrst_out_valid", {31'd0, bus.out_valid}, 0);
        check("midrst_sym_cnt",   {16'd0, bus.sym_cnt},   0);
        check("midrst_busy",      {31'd0, bus.busy},      0);
        check("midrst_queue",     exp_q.size(),           0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        push_frame(32'b11_10_11, 3, 1'b1);
        send_frame(16'b1, 1, w);
        drain("midrst_drain");

        // 7-bit frame: 9 symbols, narrow counter wraps 1..7,0,1
        push_frame(32'b11_01_10_10_10_10_10_01_11, 9, 1'b1);
        send_frame(16'b1111111, 7, w);
        drain("wrap_drain");

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end

endmodule

// File: doc/conv_encoder_tx.md
# conv_encoder_tx

Rate-1/2, constraint-length-3 (4-state) convolutional encoder: the transmit end whose symbol stream the Viterbi decoder (branch/path metric units, traceback) receives. It accepts one data bit per handshake, emits one 2-bit code symbol per bit, and terminates every frame by appending K-1 = 2 zero tail bits so the decoder trellis ends in state 00. Both sides use valid/ready flow control; the block sits between the frame source and the channel/decoder model.

## Interface
- G0, 3'b111, generator for symbol MSB (bit order {d, sr[1], sr[0]})
- G1, 3'b101, generator for symbol LSB (same bit order)
- CNT_W, 16, width of per-frame symbol counter
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  data bit offered
- in_bit  in  1  data bit
- in_last  in  1  qualifies in_bit as last data bit of frame
- in_ready  out  1  encoder accepts in_bit this cycle
- out_valid  out  1  sym valid
- sym  out  2  code symbol {c0, c1}
- sym_last  out  1  final tail symbol of frame
- out_ready  in  1  sink accepts sym
- sym_cnt  out  CNT_W  symbols emitted in current frame, including the held symbol
- busy  out  1  high while in TAIL1/TAIL2 or out_valid

## Operation
- Shift register sr[1:0] = {d(n-1), d(n-2)}; reset value 00.
- c0 = ^(G0 & {d, sr}), c1 = ^(G1 & {d, sr}); sr <= {d, sr[1]} on each encoded bit, including tail zeros.
- FSM states:
  - DATA: reset state; accept input.
  - TAIL1: emit tail zero 1.
  - TAIL2: emit tail zero 2 with sym_last=1.
- Transitions:
  - DATA -> TAIL1 on accepted bit with in_last=1.
  - TAIL1 -> TAIL2 when tail symbol 1 is loaded.
  - TAIL2 -> DATA when tail symbol 2 is loaded. sr is 00 at that point by construction.
- Output register is a single stage. It loads when (!out_valid || out_ready) and a symbol source exists: an accepted input bit in DATA, or a tail bit in TAIL1/TAIL2.
- in_ready = (state==DATA) && (!out_valid || out_ready). Inputs are never accepted during the tail.
- sym_cnt:
  - Reset 0.
  - Increments on each register load.
  - Loads 1 (not increment) on the first symbol after sym_last was transferred or after reset.
  - Wraps modulo 2^CNT_W; no saturation.
- Reset values: in_ready=1 (after rst deasserts, in DATA), out_valid=0, sym=00, sym_last=0, sym_cnt=0, busy=0, state=DATA, sr=00.
- Reset mid-frame: abandons the frame immediately. No tail is emitted and the held symbol is dropped.
- in_valid with in_bit/in_last is ignored when in_ready=0; the source must hold it.

## Timing
- Latency: bit accepted at edge n -> sym valid after edge n, sampled at edge n+1.
- Throughput: 1 symbol/cycle with out_ready=1. A frame of L bits takes L+2 cycles to drain. The next frame's first bit can be accepted the cycle after TAIL2 loads.
- sym, sym_last and sym_cnt stay stable while out_valid && !out_ready.
- Simultaneous transfer and load in the same cycle (out_valid && out_ready && new source) is a replace, not a bubble.
- No combinational path from in_valid to out_valid. in_ready depends combinationally on out_ready.

## Structure
- Shared package viterbi_pkg:
  - K=3, NUM_STATES=4, default generators 3'b111/3'b101.
  - Enum enc_state_t {DATA, TAIL1, TAIL2}.
  - Type sym_t = logic[1:0]. The decoder's branch-metric units reuse the same generators.
- One sub-module, conv_branch_out: combinational (d, sr, G0, G1) -> sym. It is shared with the decoder's expected-branch-symbol logic.

## Test plan
- Basic frame: bits 1,0,1,1(last), out_ready=1 -> sym 11,10,00,01,01,11; sym_last only on 6th; sym_cnt 1..6; sr back to 00.
- Single-bit frame: 1(last) -> 11,10,11, sym_last on 3rd; a next-frame bit 0 offered in the same cycles is held off (in_ready=0) until TAIL2 loads, then encodes to 00 with sym_cnt=1.
- Backpressure: basic frame with out_ready toggling 1,0,0,1,... -> sym and sym_cnt held stable while stalled; identical symbol sequence; no loss or duplication.
- Back-to-back frames: 0,1(last) then 1(last) with continuous valid/ready -> 00,11,10,11,11,10,11; sym_last on symbols 4 and 7; no idle cycle between.
- Reset mid-frame: assert rst after 2 bits of the basic frame -> out_valid=0, sym_cnt=0 immediately (asynchronous); a new frame 1(last) then yields 11,10,11.
- Counter wrap: CNT_W=3, 7-bit frame (9 symbols) -> sym_cnt 1..7,0,1.
